tl_ul_buffer: RTL

TL_UL_BUFFER -- requirements
Module: tl_ul_buffer

---
 rtl/tl_ul_pkg.sv | 35 +++
 rtl/tl_ul_fifo.sv | 69 ++++++
 rtl/tl_ul_buffer.sv | 69 ++++++
 3 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL beat layouts and opcode constants for the UL buffer slice.
// Field order in the packed structs matches the flat bus bit layout (first field = MSBs).
package tl_ul_pkg;

    localparam int TL_A_W = 77;
    localparam int TL_D_W = 43;

    localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] TL_A_GET              = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA  = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [0:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [1:0]  size;
        logic [0:0]  source;
        logic [0:0]  sink;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } tl_d_t;

endpackage

// File: rtl/tl_ul_fifo.sv
// Registered in-order FIFO with valid/ready on both sides; ready and valid come
// only from the occupancy register, so there is no combinational path through it.
module tl_ul_fifo #(
    parameter int WIDTH = 77,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       count
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [2:0]      DEPTH_C  = 3'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != 3'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; the cleared count hides any stale entries.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/tl_ul_buffer.sv
// TileLink-UL buffer: A channel always queued; D channel queued only when
// TL_BUFFER_D_QUEUE_EN is defined, otherwise a combinational passthrough.
module tl_ul_buffer
    import tl_ul_pkg::*;
#(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_a_valid,
    output logic              in_a_ready,
    input  logic [TL_A_W-1:0] in_a_bits,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [TL_A_W-1:0] out_a_bits,
    input  logic              out_d_valid,
    output logic              out_d_ready,
    input  logic [TL_D_W-1:0] out_d_bits,
    output logic              in_d_valid,
    input  logic              in_d_ready,
    output logic [TL_D_W-1:0] in_d_bits,
    output logic [2:0]        a_count
);

    if ((A_DEPTH != 2 && A_DEPTH != 4) || (D_DEPTH != 2 && D_DEPTH != 4)) begin : g_bad_depth
        $error("tl_ul_buffer: A_DEPTH and D_DEPTH must each be 2 or 4");
    end

    tl_ul_fifo #(
        .WIDTH (TL_A_W),
        .DEPTH (A_DEPTH)
    ) u_a_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_a_valid),
        .in_ready  (in_a_ready),
        .in_data   (in_a_bits),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready),
        .out_data  (out_a_bits),
        .count     (a_count)
    );

`ifdef TL_BUFFER_D_QUEUE_EN
    // Responses enter from the downstream side and leave toward the upstream side.
    logic [2:0] d_count;

    tl_ul_fifo #(
        .WIDTH (TL_D_W),
        .DEPTH (D_DEPTH)
    ) u_d_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (out_d_valid),
        .in_ready  (out_d_ready),
        .in_data   (out_d_bits),
        .out_valid (in_d_valid),
        .out_ready (in_d_ready),
        .out_data  (in_d_bits),
        .count     (d_count)
    );
`else
    assign in_d_valid  = out_d_valid;
    assign in_d_bits   = out_d_bits;
    assign out_d_ready = in_d_ready;
`endif

endmodule
